dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data RAM between the processor's data-memory port and a DMA/debug loader. Sits between `processor` and `RAM` in the top-level wrapper. Issues at most one RAM access per cycle and routes synchronous read data back to its owner one cycle later. An optional starvation guard bounds DMA wait time under continuous CPU traffic.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_starve_ctr.sv | 37 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   owner_t       : read-return owner encoding (NONE/CPU/DMA)
//   DEF_ADDR_W    : default RAM word-address width
//   DEF_DATA_W    : default data width
// Optional feature macro used by the arbiter: DMEM_ARB_FAIR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of consecutive denied DMA cycles.
//   clock     in  : rising-edge clock
//   reset     in  : asynchronous active-low reset
//   dma_req   in  : DMA request this cycle
//   dma_gnt   in  : DMA granted this cycle
//   force_dma out : DMA must win this cycle (limit reached, still requesting)
// Only instantiated when DMEM_ARB_FAIR_EN is defined.
module dmem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // force_dma depends only on the registered count and dma_req, so the
  // grant -> counter path closes through the register, not combinationally.
  assign force_dma = dma_req && (starve_cnt == LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data RAM between the CPU
// data port and a DMA/debug loader. One RAM access per cycle; read data
// returns to its requester the cycle after the grant.
//   clock, reset                  : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         : CPU access request (held until cpu_gnt)
//   cpu_gnt/rvalid/rdata          : CPU grant and read response
//   dma_req/we/addr/wdata         : DMA access request (held until dma_gnt)
//   dma_gnt/rvalid/rdata          : DMA grant and read response
//   ram_wEn/addr/dataIn           : RAM command from the winning port
//   ram_dataOut                   : RAM read data, one cycle after address
// Macro DMEM_ARB_FAIR_EN: when defined, DMA is forced through after
// STARVE_LIMIT consecutive denied cycles; otherwise strict CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  logic   force_dma;
  owner_t owner;

`ifdef DMEM_ARB_FAIR_EN
  dmem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clock    (clock),
    .reset    (reset),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .force_dma(force_dma)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign force_dma = 1'b0;
`endif

  // Grants are qualified by reset so nothing reaches the RAM while in reset.
  assign cpu_gnt = reset && cpu_req && !force_dma;
  assign dma_gnt = reset && dma_req && (force_dma || !cpu_req);

  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (cpu_gnt) begin
      ram_wEn    = cpu_we;
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
    end else if (dma_gnt) begin
      ram_wEn    = dma_we;
      ram_addr   = dma_addr;
      ram_dataIn = dma_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      owner <= OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      owner <= OWN_DMA;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (owner == OWN_CPU);
  assign dma_rvalid = (owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? ram_dataOut : '0;
  assign dma_rdata  = dma_rvalid ? ram_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Includes a
// behavioural RAM and a transaction-level reference model (shadow memory,
// pending-response slot, DMA wait count). Honours DMEM_ARB_FAIR_EN.
module tb_dmem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;

  dmem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  always #5 clock = ~clock;

  // Behavioural single-port synchronous RAM (environment, not the model).
  logic [DW-1:0] mem [4096];
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  function automatic logic [DW-1:0] pat(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model state.
  logic [DW-1:0] shadow [4096];
  int            pend_own = 0;   // 0 none, 1 cpu, 2 dma
  logic [DW-1:0] pend_data = '0;
  int            waitc = 0;
  int            last_win = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cpu_gnt"},    {31'd0, cpu_gnt},    '0);
    chk({tag, ".dma_gnt"},    {31'd0, dma_gnt},    '0);
    chk({tag, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, '0);
    chk({tag, ".dma_rvalid"}, {31'd0, dma_rvalid}, '0);
    chk({tag, ".cpu_rdata"},  cpu_rdata,           '0);
    chk({tag, ".dma_rdata"},  dma_rdata,           '0);
    chk({tag, ".ram_wEn"},    {31'd0, ram_wEn},    '0);
    chk({tag, ".ram_addr"},   {20'd0, ram_addr},   '0);
    chk({tag, ".ram_dataIn"}, ram_dataIn,          '0);
  endtask

  // One clock cycle: drive at negedge, compare against the model, then
  // advance the model as if the following rising edge had happened.
  task automatic cycle(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    int win;
    bit frc;
    @(negedge clock);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    frc = 1'b0;
`ifdef DMEM_ARB_FAIR_EN
    frc = dr && (waitc >= LIM);
`endif
    if (cr && !frc)  win = 1;
    else if (dr)     win = 2;
    else             win = 0;
    chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, win == 1});
    chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, win == 2});
    chk("ram_wEn", {31'd0, ram_wEn},
        {31'd0, (win == 1) ? cw : (win == 2) ? dw : 1'b0});
    chk("ram_addr", {20'd0, ram_addr},
        {20'd0, (win == 1) ? ca : (win == 2) ? da : 12'd0});
    chk("ram_dataIn", ram_dataIn, (win == 1) ? cd : (win == 2) ? dd : 32'd0);
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, pend_own == 1});
    chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, pend_own == 2});
    chk("cpu_rdata", cpu_rdata, (pend_own == 1) ? pend_data : 32'd0);
    chk("dma_rdata", dma_rdata, (pend_own == 2) ? pend_data : 32'd0);
    last_win = win;
    pend_own = 0;
    if (win == 1) begin
      if (cw) shadow[ca] = cd;
      else begin pend_own = 1; pend_data = shadow[ca]; end
    end else if (win == 2) begin
      if (dw) shadow[da] = dd;
      else begin pend_own = 2; pend_data = shadow[da]; end
    end
    if (dr && win != 2) waitc = (waitc < LIM) ? waitc + 1 : waitc;
    else                waitc = 0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          e_cgnt, e_dgnt, e_we;
    logic [AW-1:0] e_addr;
    logic          e_crv, e_drv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tab [8];

  logic          rcr, rcw, rdr, rdw;
  logic [AW-1:0] rca, rda;
  logic [DW-1:0] rcd, rdd;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= pat(i);
      shadow[i] = pat(i);
    end
    mem[12'h010] <= 32'hDEAD_BEEF;
    shadow[12'h010] = 32'hDEAD_BEEF;

    // Requests asserted while in reset: nothing may be granted.
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 12'h123; dma_addr = 12'h321;
    #1;
    chk_all_zero("reset");
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b1;

    tab[0] = '{1'b0,1'b0,12'h000,32'h0,         1'b0,1'b0,12'h000,32'h0,  1'b0,1'b0,1'b0,12'h000, 1'b0,1'b0,32'h0};
    tab[1] = '{1'b1,1'b0,12'h010,32'h0,         1'b0,1'b0,12'h000,32'h0,  1'b1,1'b0,1'b0,12'h010, 1'b0,1'b0,32'h0};
    tab[2] = '{1'b0,1'b0,12'h000,32'h0,         1'b1,1'b1,12'h020,32'hA5, 1'b0,1'b1,1'b1,12'h020, 1'b1,1'b0,32'hDEAD_BEEF};
    tab[3] = '{1'b1,1'b1,12'h004,32'h55,        1'b1,1'b0,12'h004,32'h0,  1'b1,1'b0,1'b1,12'h004, 1'b0,1'b0,32'h0};
    tab[4] = '{1'b0,1'b0,12'h000,32'h0,         1'b1,1'b0,12'h004,32'h0,  1'b0,1'b1,1'b0,12'h004, 1'b0,1'b0,32'h0};
    tab[5] = '{1'b1,1'b1,12'hFFF,32'hFFFF_FFFF, 1'b0,1'b0,12'h000,32'h0,  1'b1,1'b0,1'b1,12'hFFF, 1'b0,1'b1,32'h55};
    tab[6] = '{1'b1,1'b0,12'hFFF,32'h0,         1'b0,1'b0,12'h000,32'h0,  1'b1,1'b0,1'b0,12'hFFF, 1'b0,1'b0,32'h0};
    tab[7] = '{1'b0,1'b0,12'h000,32'h0,         1'b0,1'b0,12'h000,32'h0,  1'b0,1'b0,1'b0,12'h000, 1'b1,1'b0,32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      cycle(tab[i].cr, tab[i].cw, tab[i].ca, tab[i].cd, tab[i].dr, tab[i].dw, tab[i].da, tab[i].dd);
      chk("tab.cpu_gnt",  {31'd0, cpu_gnt},    {31'd0, tab[i].e_cgnt});
      chk("tab.dma_gnt",  {31'd0, dma_gnt},    {31'd0, tab[i].e_dgnt});
      chk("tab.ram_wEn",  {31'd0, ram_wEn},    {31'd0, tab[i].e_we});
      chk("tab.ram_addr", {20'd0, ram_addr},   {20'd0, tab[i].e_addr});
      chk("tab.cpu_rv",   {31'd0, cpu_rvalid}, {31'd0, tab[i].e_crv});
      chk("tab.dma_rv",   {31'd0, dma_rvalid}, {31'd0, tab[i].e_drv});
      chk("tab.rdata",    cpu_rdata | dma_rdata, tab[i].e_rd);
    end

    // Continuous contention.
`ifdef DMEM_ARB_FAIR_EN
    for (int k = 0; k < 18; k++) begin
      cycle(1'b1, 1'b0, 12'h040, '0, 1'b1, 1'b0, 12'h100, '0);
      chk("starve.dma_gnt", {31'd0, dma_gnt}, {31'd0, (k == 8) || (k == 17)});
    end
`else
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 12'h040, '0, 1'b1, 1'b0, 12'h100, '0);
      chk("strict.dma_gnt", {31'd0, dma_gnt}, '0);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h100, '0);
    chk("strict.release", {31'd0, dma_gnt}, 32'd1);
`endif
    idle();

    // Pipelined DMA reads.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'(12'h100 + k), '0);
      else       idle();
      if (k >= 1 && k <= 3) begin
        chk("pipe.dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
        chk("pipe.dma_rdata", dma_rdata, pat(12'h100 + k - 1));
      end
    end

    // Reset asserted between a read grant and its response edge.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; dma_req = 1'b0;
    #1;
    chk("rst.grant", {31'd0, cpu_gnt}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("rst.low");
    pend_own = 0; waitc = 0; last_win = 0;
    @(posedge clock); #1;
    chk_all_zero("rst.edge");
    #1 reset = 1'b1;
    cycle(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    chk("rst.regrant", {31'd0, cpu_gnt}, 32'd1);
    idle();
    chk("rst.rdata", cpu_rdata, 32'hDEAD_BEEF);

    // Randomized traffic; a refused request holds its fields.
    rcr = 0; rcw = 0; rca = '0; rcd = '0; rdr = 0; rdw = 0; rda = '0; rdd = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!(rcr && last_win != 1)) begin
        rcr = ($urandom_range(0, 99) < 60);
        rcw = $urandom_range(0, 1) == 1;
        rca = 12'($urandom_range(0, 15));
        rcd = $urandom;
      end
      if (!(rdr && last_win != 2)) begin
        rdr = ($urandom_range(0, 99) < 50);
        rdw = $urandom_range(0, 1) == 1;
        rda = 12'($urandom_range(0, 15));
        rdd = $urandom;
      end
      cycle(rcr, rcw, rca, rcd, rdr, rdw, rda, rdd);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
